// File: rtl/serial_chunk_adder_if.sv
// Operand/result bundle for the serial chunk adder.
// The master drives the request side (start, op, cin, a, b).
// The slave returns the result side (sum, cout, overflow, busy, done).
interface serial_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, op, cin, a, b,
        input  sum, cout, overflow, busy, done
    );

    modport slave (
        input  start, op, cin, a, b,
        output sum, cout, overflow, busy, done
    );
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle add/subtract unit.
// It pushes WIDTH-bit operands through a single CHUNK-bit ripple-carry slice,
// one chunk per clock, and keeps the inter-chunk carry in a register.
// Subtraction is computed as a + ~b + 1: b is inverted when it is captured,
// and the carry register is seeded with 1.
module serial_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_chunk_adder_if.slave   bus
);
    localparam int N   = WIDTH / CHUNK;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int MSB = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_overflow;
    logic             r_busy;
    logic             r_done;
    int               w_base;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_slice;

    // Explicit CHUNK-bit ripple-carry slice; result is {carry_out, sum}.
    function automatic logic [CHUNK:0] ripple_add(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             c_in
    );
        logic [CHUNK-1:0] s;
        logic             c;
        c = c_in;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
        end
        return {c, s};
    endfunction

    assign w_base    = int'(r_cnt) * CHUNK;
    assign w_a_chunk = r_a[w_base +: CHUNK];
    assign w_b_chunk = r_b[w_base +: CHUNK];
    assign w_slice   = ripple_add(w_a_chunk, w_b_chunk, r_carry);
    assign w_last    = (r_cnt == LAST);

    // Next-state decode; a new start is accepted from IDLE and from DONE (back-to-back).
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done decodes of the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == S_RUN);
            r_done  <= (w_state_next == S_DONE);
        end
    end

    // Operand capture on accept, then one chunk per cycle into sum/carry; flags load on the last chunk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.op ? ~bus.b : bus.b;
            r_carry <= bus.op ? 1'b1 : bus.cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_sum[w_base +: CHUNK] <= w_slice[CHUNK-1:0];
            r_carry                <= w_slice[CHUNK];
            if (w_last) begin
                r_cnt      <= '0;
                r_cout     <= w_slice[CHUNK];
                r_overflow <= (r_a[MSB] == r_b[MSB]) && (w_slice[CHUNK-1] != r_a[MSB]);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_overflow;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
endmodule
